// File: rtl/trace_capture_buffer.sv
// Instruction-trace recorder: samples {PCF, InstrF} into a circular buffer, stops PostCount entries after a trigger.
// Latency: a sample is stored on the edge where en is seen; RdPC/RdInstr are registered, one cycle after RdAddr.
// Backpressure: none; the recorder only observes the fetch stage and never stalls the core.
module trace_capture_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             en,
    input  logic [WIDTH-1:0] PCF,
    input  logic [WIDTH-1:0] InstrF,
    input  logic [WIDTH-1:0] TrigMatch,
    input  logic [WIDTH-1:0] TrigMask,
    input  logic [AW-1:0]    PostCount,
    input  logic [AW-1:0]    RdAddr,
    output logic [WIDTH-1:0] RdPC,
    output logic [WIDTH-1:0] RdInstr,
    output logic [1:0]       State,
    output logic [AW:0]      Count,
    output logic [AW-1:0]    TrigIdx,
    output logic             Wrapped,
    output logic             Done
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ARMED     = 2'd1,
        S_TRIGGERED = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    // Count saturates at a full buffer; held AW+1 bits wide so DEPTH itself is representable.
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t          state;
    state_t          state_nxt;

    logic [AW-1:0]   wptr;
    logic [AW:0]     count;
    logic [AW-1:0]   trig_phys;
    logic [AW-1:0]   remaining;
    logic            wrapped;
    logic [WIDTH-1:0] rd_pc;
    logic [WIDTH-1:0] rd_instr;

    logic [WIDTH-1:0] mem_pc    [DEPTH];
    logic [WIDTH-1:0] mem_instr [DEPTH];

    // Control strobes produced by the next-state logic.
    logic            hit;
    logic            restart;
    logic            do_write;
    logic            take_trig;
    logic            dec_rem;

    // Oldest live entry and the physical slot addressed by the logical read index.
    logic [AW-1:0]   oldest;
    logic [AW-1:0]   rd_phys;
    logic            rd_oob;

    assign hit     = en && (((InstrF ^ TrigMatch) & TrigMask) == '0);
    assign oldest  = wptr - count[AW-1:0];
    assign rd_phys = oldest + RdAddr;
    assign rd_oob  = ({1'b0, RdAddr} >= count);

    // State register; reset overrides everything, including a same-cycle arm.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and write/trigger strobes; arm restarts from any state and suppresses that cycle's sample.
    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        do_write  = 1'b0;
        take_trig = 1'b0;
        dec_rem   = 1'b0;
        if (arm) begin
            state_nxt = S_ARMED;
            restart   = 1'b1;
        end else begin
            case (state)
                S_ARMED: begin
                    if (en) begin
                        do_write = 1'b1;
                        if (hit) begin
                            take_trig = 1'b1;
                            // A zero post-count means the trigger entry closes the window.
                            state_nxt = (PostCount == '0) ? S_DONE : S_TRIGGERED;
                        end
                    end
                end
                S_TRIGGERED: begin
                    // Trigger is not re-evaluated here; only en-qualified samples consume the budget.
                    if (en) begin
                        do_write = 1'b1;
                        dec_rem  = 1'b1;
                        if (remaining == AW'(1)) begin
                            state_nxt = S_DONE;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE hold; DONE keeps the window frozen for readout.
                end
            endcase
        end
    end

    // Pointer, occupancy, trigger slot and post-trigger budget bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr      <= '0;
            count     <= '0;
            wrapped   <= 1'b0;
            trig_phys <= '0;
            remaining <= '0;
        end else if (restart) begin
            wptr      <= '0;
            count     <= '0;
            wrapped   <= 1'b0;
            trig_phys <= '0;
            remaining <= '0;
        end else if (do_write) begin
            wptr <= wptr + AW'(1);
            if (count == FULL) begin
                wrapped <= 1'b1;
            end else begin
                count <= count + (AW+1)'(1);
            end
            if (take_trig) begin
                trig_phys <= wptr;
                remaining <= PostCount;
            end else if (dec_rem) begin
                remaining <= remaining - AW'(1);
            end
        end
    end

    // Trace storage; contents are never reset and are only exposed through in-range reads.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_pc[wptr]    <= PCF;
            mem_instr[wptr] <= InstrF;
        end
    end

    // Registered readout; indices at or beyond Count read as zero so stale data never leaks.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pc    <= '0;
            rd_instr <= '0;
        end else if (rd_oob) begin
            rd_pc    <= '0;
            rd_instr <= '0;
        end else begin
            rd_pc    <= mem_pc[rd_phys];
            rd_instr <= mem_instr[rd_phys];
        end
    end

    assign RdPC    = rd_pc;
    assign RdInstr = rd_instr;
    assign State   = state;
    assign Count   = count;
    assign TrigIdx = trig_phys - oldest;
    assign Wrapped = wrapped;
    assign Done    = (state == S_DONE);

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Bench for trace_capture_buffer at DEPTH=16: constant read tables plus hand-built capture sequences.
// Read expectations go through a queue when RdAddr is driven and are compared when the registered output appears.
// Inputs change 1ns after each rising edge; outputs are sampled at the same point.
module tb_trace_capture_buffer;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          arm;
    logic          en;
    logic [W-1:0]  PCF;
    logic [W-1:0]  InstrF;
    logic [W-1:0]  TrigMatch;
    logic [W-1:0]  TrigMask;
    logic [AW-1:0] PostCount;
    logic [AW-1:0] RdAddr;
    logic [W-1:0]  RdPC;
    logic [W-1:0]  RdInstr;
    logic [1:0]    State;
    logic [AW:0]   Count;
    logic [AW-1:0] TrigIdx;
    logic          Wrapped;
    logic          Done;

    trace_capture_buffer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .arm(arm), .en(en),
        .PCF(PCF), .InstrF(InstrF), .TrigMatch(TrigMatch), .TrigMask(TrigMask),
        .PostCount(PostCount), .RdAddr(RdAddr),
        .RdPC(RdPC), .RdInstr(RdInstr), .State(State), .Count(Count),
        .TrigIdx(TrigIdx), .Wrapped(Wrapped), .Done(Done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  pc;
        logic [W-1:0]  instr;
    } rd_vec_t;

    typedef struct {
        logic [W-1:0] pc;
        logic [W-1:0] instr;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t    exp_q[$];
    rd_vec_t t1_tab[5];

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Drive a read index, queue its expectation, and compare once the registered result is out.
    task automatic rd(input logic [AW-1:0] addr, input logic [W-1:0] pc, input logic [W-1:0] instr);
        exp_t e;
        RdAddr = addr;
        exp_q.push_back('{pc: pc, instr: instr, addr: addr});
        tick();
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: queue empty, expected 1 entry");
        end else begin
            e = exp_q.pop_front();
            check($sformatf("rdpc[%0d]", e.addr), {32'h0, RdPC}, {32'h0, e.pc});
            check($sformatf("rdinstr[%0d]", e.addr), {32'h0, RdInstr}, {32'h0, e.instr});
        end
    endtask

    task automatic pulse_arm(input logic with_en);
        arm = 1'b1;
        en  = with_en;
        PCF = 32'hDEAD_BEEF;
        InstrF = 32'h0;
        tick();
        arm = 1'b0;
        en  = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic [1:0] st, input logic [AW:0] cnt,
                                input logic [AW-1:0] tidx, input logic wr);
        check({tag, ".state"},   {62'h0, State},   {62'h0, st});
        check({tag, ".count"},   {59'h0, Count},   {59'h0, cnt});
        check({tag, ".trigidx"}, {60'h0, TrigIdx}, {60'h0, tidx});
        check({tag, ".wrapped"}, {63'h0, Wrapped}, {63'h0, wr});
        check({tag, ".done"},    {63'h0, Done},    {63'h0, (st == 2'd3)});
    endtask

    // Every en-qualified sample of T3: index into the stimulus that should land in the buffer.
    int t3_idx[5] = '{0, 1, 3, 6, 8};

    initial begin
        reset = 1'b1; arm = 1'b0; en = 1'b0;
        PCF = '0; InstrF = '0; TrigMatch = '0; TrigMask = '0;
        PostCount = '0; RdAddr = '0;

        for (int i = 0; i < 4; i++) begin
            t1_tab[i] = '{addr: AW'(i), pc: 32'h100 + 32'(4 * i), instr: 32'hE000_0000 + 32'(i)};
        end
        t1_tab[4] = '{addr: AW'(4), pc: 32'h0, instr: 32'h0};

        // Reset state.
        tick(); tick();
        check_status("reset", 2'd0, 5'd0, 4'd0, 1'b0);
        check("reset.rdpc", {32'h0, RdPC}, 64'h0);
        check("reset.rdinstr", {32'h0, RdInstr}, 64'h0);
        reset = 1'b0;

        // T1: zero mask triggers on the first sample, three more entries follow.
        TrigMask = '0; TrigMatch = 32'h1234_5678; PostCount = 4'd3;
        pulse_arm(1'b1);
        check("t1.arm_state", {62'h0, State}, 64'd1);
        check("t1.arm_no_sample", {59'h0, Count}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            en = 1'b1;
            PCF = 32'h100 + 32'(4 * i);
            InstrF = 32'hE000_0000 + 32'(i);
            tick();
            if (i == 0) check("t1.triggered", {62'h0, State}, 64'd2);
        end
        en = 1'b0;
        check_status("t1", 2'd3, 5'd4, 4'd0, 1'b0);
        foreach (t1_tab[k]) rd(t1_tab[k].addr, t1_tab[k].pc, t1_tab[k].instr);
        // Read latency: output holds its old value until the next edge.
        RdAddr = 4'd2;
        #2;
        check("t1.latency_hold", {32'h0, RdPC}, 64'h0);
        tick();
        check("t1.latency_update", {32'h0, RdPC}, 64'h108);

        // T2: full mask, trigger on the 31st sample, buffer wraps.
        TrigMask = 32'hFFFF_FFFF; TrigMatch = 32'h1AFF_FFFA; PostCount = 4'd5;
        pulse_arm(1'b0);
        for (int i = 0; i < 40; i++) begin
            en = 1'b1;
            PCF = 32'h2000 + 32'(4 * i);
            InstrF = (i == 30) ? 32'h1AFF_FFFA : 32'hE1A0_0000 + 32'(i);
            tick();
            if (i == 29) check("t2.armed_pre_hit", {62'h0, State}, 64'd1);
            if (i == 30) check("t2.triggered", {62'h0, State}, 64'd2);
        end
        en = 1'b0;
        check_status("t2", 2'd3, 5'd16, 4'd10, 1'b1);
        for (int a = 0; a < 16; a++) begin
            rd(AW'(a), 32'h2000 + 32'(4 * (20 + a)),
               (a == 10) ? 32'h1AFF_FFFA : 32'hE1A0_0000 + 32'(20 + a));
        end

        // T5: reset and arm together while ARMED; reset wins.
        RdAddr = 4'd0;
        pulse_arm(1'b0);
        check("t5.armed", {62'h0, State}, 64'd1);
        reset = 1'b1; arm = 1'b1;
        tick();
        reset = 1'b0; arm = 1'b0;
        check_status("t5", 2'd0, 5'd0, 4'd0, 1'b0);
        check("t5.rdpc", {32'h0, RdPC}, 64'h0);
        check("t5.rdinstr", {32'h0, RdInstr}, 64'h0);

        // T3: en toggling in TRIGGERED; only en-high cycles are written.
        TrigMask = 32'hFFFF_FFFF; TrigMatch = 32'hAAAA_0000; PostCount = 4'd3;
        pulse_arm(1'b0);
        for (int i = 0; i < 10; i++) begin
            en = (i == 0 || i == 1 || i == 3 || i == 6 || i == 8 || i == 9);
            PCF = 32'h3000 + 32'(4 * i);
            InstrF = (i == 1) ? 32'hAAAA_0000 : 32'hE300_0000 + 32'(i);
            tick();
            if (i == 1) check("t3.triggered", {62'h0, State}, 64'd2);
            if (i == 2) check("t3.en_low_hold", {59'h0, Count}, 64'd2);
        end
        en = 1'b0;
        check_status("t3", 2'd3, 5'd5, 4'd1, 1'b0);
        for (int a = 0; a < 5; a++) begin
            rd(AW'(a), 32'h3000 + 32'(4 * t3_idx[a]),
               (t3_idx[a] == 1) ? 32'hAAAA_0000 : 32'hE300_0000 + 32'(t3_idx[a]));
        end
        rd(4'd5, 32'h0, 32'h0);

        // T4: arm pulsed mid-TRIGGERED restarts and hides earlier data.
        TrigMask = '0; PostCount = 4'd10;
        pulse_arm(1'b0);
        for (int i = 0; i < 3; i++) begin
            en = 1'b1;
            PCF = 32'h4000 + 32'(4 * i);
            InstrF = 32'hE400_0000 + 32'(i);
            tick();
        end
        check("t4.pre_state", {62'h0, State}, 64'd2);
        check("t4.pre_count", {59'h0, Count}, 64'd3);
        pulse_arm(1'b1);
        check("t4.rearm_state", {62'h0, State}, 64'd1);
        check("t4.rearm_count", {59'h0, Count}, 64'd0);
        rd(4'd0, 32'h0, 32'h0);
        rd(4'd1, 32'h0, 32'h0);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
